bcd_time_counter: RTL and testbench
===================================

Name: bcd_time_counter

Overview:
- Upstream time-keeping stage of the digital clock.
- Divides the system clock down to a 1 Hz tick and maintains 24-hour time (HH:MM:SS) as six BCD digits.
- Each digit feeds one 4-bit input of a per-digit seven-segment decoder.
- Supports a set mode: the user can step the minutes and hours, and can clear the seconds.

Parameters:
TICKS_PER_SEC, 50_000_000, number of clk cycles per second; must be >= 2; prescaler width = $clog2(TICKS_PER_SEC).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
run_en  input  1  1 = timekeeping runs; 0 = prescaler and time frozen
set_en  input  1  1 = set mode; timekeeping suspended, inc_pulse active
set_sel  input  2  field selected in set mode: 0 = seconds, 1 = minutes, 2 = hours, 3 = none
inc_pulse  input  1  synchronous, already debounced; each high cycle = one step of the selected field
hr_tens  output  4  BCD 0-2
hr_ones  output  4  BCD 0-9 (0-3 when hr_tens = 2)
min_tens  output  4  BCD 0-5
min_ones  output  4  BCD 0-9
sec_tens  output  4  BCD 0-5
sec_ones  output  4  BCD 0-9
sec_tick  output  1  one-cycle pulse each time seconds advance in run mode
day_tick  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset: asynchronous, active-high. On reset assertion, all digits go to 0 (00:00:00), the prescaler goes to 0, and sec_tick and day_tick go to 0. The block resumes on the first clk edge after reset deasserts. Reset mid-second discards the partial prescaler count.
- All outputs are registered. Digits, sec_tick and day_tick change on the same clk edge. There is no combinational path from any input to any output.
- Counting condition: count = run_en & ~set_en.
  - When count = 1, the prescaler increments each cycle.
  - When the prescaler reaches TICKS_PER_SEC-1, it wraps to 0 on the next edge. On that same edge sec_tick = 1 and the time advances by one second.
  - When count = 0 because run_en = 0 (set_en = 0), the prescaler holds its value. Resuming continues the partial second.
  - When set_en = 1, the prescaler is cleared to 0 and held. Leaving set mode starts a full fresh second.
- Time advance (carry chain, one edge):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 (at :59) carries into minutes.
  - Minutes 59 -> 00 carries into hours.
  - Hours 23 -> 00 on a minute carry sets day_tick = 1 for that cycle.
  - 09 -> 10 and 19 -> 20 increment the tens digits normally.
  - 23 wraps directly to 00; never 24.
- Set mode (set_en = 1), evaluated per cycle when inc_pulse = 1:
  - set_sel = 0: seconds cleared to 00.
  - set_sel = 1: minutes +1, 59 wraps to 00, no carry into hours.
  - set_sel = 2: hours +1, 23 wraps to 00, no day_tick.
  - set_sel = 3: no change.
  - inc_pulse held high steps once per cycle.
  - sec_tick = 0 and day_tick = 0 throughout set mode.
- inc_pulse is ignored when set_en = 0.
- When set_en rises on the same edge the prescaler would have wrapped, set_en wins: no second advance and no sec_tick.
- Illegal digit values are unreachable from reset. No recovery logic is required beyond reset.

Test Plan:
- Reset then count: TICKS_PER_SEC = 4, run_en = 1, set_en = 0. Expect the first sec_tick on the 4th clk edge after reset release, and digits 00:00:01 on that same edge. After 10 ticks, digits read 00:00:10, i.e. sec_tens = 1, sec_ones = 0.
- Full rollover: set the time to 23:59:58, then run 2 seconds. Expect 23:59:59, then 00:00:00. day_tick = 1 for exactly one cycle, coincident with the second sec_tick.
- Set mode wraps: set_en = 1, set_sel = 2, 25 inc_pulses from 00:00:00 -> hours = 01. Then set_sel = 1, 61 pulses -> minutes = 01, hours still 01. No sec_tick and no day_tick during set mode.
- Pause and resume: run_en = 0 with the prescaler at 2 for 20 cycles -> no change. run_en = 1 -> next sec_tick after exactly 2 more edges.
- Set entry at wrap / clear seconds: assert set_en on the prescaler-wrap edge -> no advance and no sec_tick. Then set_sel = 0 + inc_pulse -> seconds = 00. Deassert set_en -> next sec_tick exactly 4 edges later.
- Async reset mid-run at 12:34:56: assert reset between clk edges -> all digits 0 immediately, without waiting for clk. sec_tick and day_tick = 0.

Source files
------------

// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Time-keeping stage of the digital clock. Divides clk down to a 1 Hz tick
//   and keeps 24-hour time as six BCD digits (HH:MM:SS), one per
//   seven-segment decoder. A set mode lets the user step minutes/hours and
//   clear the seconds.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset (time 00:00:00, prescaler 0)
//   run_en     1 = timekeeping runs, 0 = prescaler and time frozen
//   set_en     1 = set mode (prescaler cleared, inc_pulse active)
//   set_sel    set-mode field: 0 sec (clear), 1 min, 2 hours, 3 none
//   inc_pulse  one step of the selected field per high cycle
//   hr_tens .. sec_ones   BCD time digits (registered)
//   sec_tick   one-cycle pulse when seconds advance in run mode
//   day_tick   one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
module bcd_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       inc_pulse,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       sec_tick,
  output logic       day_tick
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hr_tens_q, hr_ones_q, min_tens_q, min_ones_q, sec_tens_q, sec_ones_q;
  logic [3:0]    hr_tens_d, hr_ones_d, min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
  logic          sec_tick_q, sec_tick_d, day_tick_q, day_tick_d;

  // Incremented minute/hour fields, shared by the run-mode carry chain and
  // the set-mode stepping so both wrap identically.
  logic [3:0] min_ones_inc, min_tens_inc, hr_ones_inc, hr_tens_inc;
  logic       min_wrap, hr_wrap;

  always_comb begin
    min_wrap = (min_tens_q == 4'd5) && (min_ones_q == 4'd9);
    if (min_ones_q == 4'd9) begin
      min_ones_inc = '0;
      min_tens_inc = (min_tens_q == 4'd5) ? '0 : min_tens_q + 4'd1;
    end else begin
      min_ones_inc = min_ones_q + 4'd1;
      min_tens_inc = min_tens_q;
    end
  end

  always_comb begin
    hr_wrap = (hr_tens_q == 4'd2) && (hr_ones_q == 4'd3);
    if (hr_wrap) begin
      hr_ones_inc = '0;
      hr_tens_inc = '0;
    end else if (hr_ones_q == 4'd9) begin
      hr_ones_inc = '0;
      hr_tens_inc = hr_tens_q + 4'd1;
    end else begin
      hr_ones_inc = hr_ones_q + 4'd1;
      hr_tens_inc = hr_tens_q;
    end
  end

  always_comb begin
    presc_d    = presc_q;
    hr_tens_d  = hr_tens_q;
    hr_ones_d  = hr_ones_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;

    if (set_en) begin
      // Set mode takes priority over a coincident prescaler wrap.
      presc_d = '0;
      if (inc_pulse) begin
        unique case (set_sel)
          2'd0: begin
            sec_tens_d = '0;
            sec_ones_d = '0;
          end
          2'd1: begin
            min_tens_d = min_tens_inc;
            min_ones_d = min_ones_inc;
          end
          2'd2: begin
            hr_tens_d = hr_tens_inc;
            hr_ones_d = hr_ones_inc;
          end
          default: ;
        endcase
      end
    end else if (run_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d    = '0;
        sec_tick_d = 1'b1;
        if (sec_ones_q == 4'd9) begin
          sec_ones_d = '0;
          if (sec_tens_q == 4'd5) begin
            sec_tens_d = '0;
            min_tens_d = min_tens_inc;
            min_ones_d = min_ones_inc;
            if (min_wrap) begin
              hr_tens_d  = hr_tens_inc;
              hr_ones_d  = hr_ones_inc;
              day_tick_d = hr_wrap;
            end
          end else begin
            sec_tens_d = sec_tens_q + 4'd1;
          end
        end else begin
          sec_ones_d = sec_ones_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      hr_tens_q  <= '0;
      hr_ones_q  <= '0;
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hr_tens_q  <= hr_tens_d;
      hr_ones_q  <= hr_ones_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign hr_tens  = hr_tens_q;
  assign hr_ones  = hr_ones_q;
  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign sec_tick = sec_tick_q;
  assign day_tick = day_tick_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter
//   Self-checking bench for bcd_time_counter with TICKS_PER_SEC = 4. A
//   seconds-of-day reference model predicts each cycle's outputs; the
//   prediction is queued when inputs are driven and compared after the edge.
module tb_bcd_time_counter;

  localparam int TPS = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run_en = 1'b0;
  logic       set_en = 1'b0;
  logic [1:0] set_sel = 2'd3;
  logic       inc_pulse = 1'b0;
  logic [3:0] hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones;
  logic       sec_tick, day_tick;

  bcd_time_counter #(.TICKS_PER_SEC(TPS)) dut (
    .clk       (clk),
    .reset     (reset),
    .run_en    (run_en),
    .set_en    (set_en),
    .set_sel   (set_sel),
    .inc_pulse (inc_pulse),
    .hr_tens   (hr_tens),
    .hr_ones   (hr_ones),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .sec_tick  (sec_tick),
    .day_tick  (day_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_tod   = 0;
  int m_presc = 0;

  logic [25:0] sb_q[$];
  logic [23:0] obs_digits;
  logic        obs_tick, obs_day;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] tod_bcd(input int tod);
    int hh, mm, ss;
    hh = tod / 3600;
    mm = (tod / 60) % 60;
    ss = tod % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic logic [23:0] dut_digits();
    return {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  // Drive one cycle of inputs, predict, clock, compare.
  task automatic step(input bit r, input bit run, input bit set,
                      input logic [1:0] sel, input bit inc);
    bit st, dt;
    int hh, mm, ss;
    st = 1'b0;
    dt = 1'b0;
    reset = r; run_en = run; set_en = set; set_sel = sel; inc_pulse = inc;
    hh = m_tod / 3600;
    mm = (m_tod / 60) % 60;
    ss = m_tod % 60;
    if (r) begin
      m_tod = 0;
      m_presc = 0;
    end else if (set) begin
      m_presc = 0;
      if (inc) begin
        case (sel)
          2'd0: m_tod = hh * 3600 + mm * 60;
          2'd1: m_tod = hh * 3600 + ((mm + 1) % 60) * 60 + ss;
          2'd2: m_tod = ((hh + 1) % 24) * 3600 + mm * 60 + ss;
          default: ;
        endcase
      end
    end else if (run) begin
      if (m_presc == TPS - 1) begin
        m_presc = 0;
        st = 1'b1;
        if (m_tod == 86399) dt = 1'b1;
        m_tod = (m_tod + 1) % 86400;
      end else begin
        m_presc++;
      end
    end
    sb_q.push_back({tod_bcd(m_tod), st, dt});
    @(posedge clk);
    #1;
    obs_digits = dut_digits();
    obs_tick = sec_tick;
    obs_day = day_tick;
    check("cycle", {6'd0, obs_digits, obs_tick, obs_day}, {6'd0, sb_q.pop_front()});
  endtask

  task automatic run_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 2'd3, 0);
  endtask

  task automatic set_steps(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) step(0, 1, 1, sel, 1);
  endtask

  // Run until sec_tick is seen; returns edges taken, or -1 if budget expires.
  task automatic edges_to_tick(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      step(0, 1, 0, 2'd3, 0);
      if (obs_tick) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int day_cnt, day_off_tick;
    logic [23:0] saved;

    // reset state
    step(1, 1, 0, 2'd3, 0);
    step(1, 1, 0, 2'd3, 0);
    check("reset_digits", {8'd0, obs_digits}, 32'h0);
    check("reset_ticks", {30'd0, obs_tick, obs_day}, 32'h0);

    // reset then count
    edges_to_tick(10, n);
    check("first_tick_edge", n, 4);
    check("first_tick_digits", {8'd0, obs_digits}, 32'h000001);
    run_steps(9 * TPS);
    check("ten_sec", {8'd0, obs_digits}, 32'h000010);

    // reach 23:59:58 then full rollover
    run_steps(48 * TPS);
    set_steps(2'd2, 23);
    set_steps(2'd1, 59);
    check("set_235958", {8'd0, obs_digits}, 32'h235958);
    day_cnt = 0;
    day_off_tick = 0;
    for (int i = 0; i < 2 * TPS; i++) begin
      step(0, 1, 0, 2'd3, 0);
      if (obs_day) day_cnt++;
      if (obs_day && !obs_tick) day_off_tick++;
    end
    check("rollover_digits", {8'd0, obs_digits}, 32'h000000);
    check("day_tick_count", day_cnt, 1);
    check("day_tick_with_sec", day_off_tick, 0);

    // set mode wraps
    set_steps(2'd2, 25);
    check("hours_wrap", {8'd0, obs_digits}, 32'h010000);
    set_steps(2'd1, 61);
    check("minutes_wrap", {8'd0, obs_digits}, 32'h010100);

    // pause and resume with prescaler at 2
    run_steps(2);
    saved = obs_digits;
    for (int i = 0; i < 20; i++) step(0, 0, 0, 2'd3, 0);
    check("pause_hold", {8'd0, obs_digits}, {8'd0, saved});
    edges_to_tick(10, n);
    check("resume_edges", n, 2);

    // set entry on the wrap edge, then clear seconds
    run_steps(5 * TPS);
    for (int i = 0; i < 2 * TPS && m_presc != TPS - 1; i++) step(0, 1, 0, 2'd3, 0);
    saved = obs_digits;
    step(0, 1, 1, 2'd3, 0);
    check("set_at_wrap_tick", {31'd0, obs_tick}, 32'h0);
    check("set_at_wrap_hold", {8'd0, obs_digits}, {8'd0, saved});
    step(0, 1, 1, 2'd0, 1);
    check("clear_seconds", {24'd0, obs_digits[7:0]}, 32'h0);
    edges_to_tick(10, n);
    check("fresh_second_edges", n, 4);

    // go to 12:34:56, then async reset between edges
    set_steps(2'd2, (12 - m_tod / 3600 + 24) % 24);
    set_steps(2'd1, (34 - (m_tod / 60) % 60 + 60) % 60);
    step(0, 1, 1, 2'd0, 1);
    run_steps(56 * TPS);
    check("at_123456", {8'd0, obs_digits}, 32'h123456);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_digits", {8'd0, dut_digits()}, 32'h0);
    check("async_reset_ticks", {30'd0, sec_tick, day_tick}, 32'h0);
    m_tod = 0;
    m_presc = 0;
    step(1, 1, 0, 2'd3, 0);
    edges_to_tick(10, n);
    check("post_reset_edges", n, 4);

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
